// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill controller: burst-reads the missed line, writes it
// into the victim way, forwards the critical word early and commits the tag.
module icache_refill_ctrl #(
  parameter int TAG_WIDTH    = 20,
  parameter int OFFSET_WIDTH = 5,
  parameter int LINE_NUM     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    miss_req,
  input  logic [31:0]             miss_addr,
  input  logic [31:0]             victim_id,
  output logic                    busy,
  output logic                    refill_done,
  output logic                    mem_rd_req,
  output logic [31:0]             mem_rd_addr,
  output logic [7:0]              mem_rd_len,
  input  logic                    mem_rd_ack,
  input  logic                    mem_rd_valid,
  input  logic [31:0]             mem_rd_data,
  input  logic                    mem_rd_last,
  output logic                    mem_rd_ready,
  output logic                    line_we,
  output logic [31:0]             line_way,
  output logic [OFFSET_WIDTH-3:0] line_word_idx,
  output logic [31:0]             line_wdata,
  output logic                    tag_we,
  output logic [TAG_WIDTH-1:0]    tag_out,
  output logic                    crit_valid,
  output logic [31:0]             crit_data,
  output logic                    protocol_err
);

  localparam int CW    = OFFSET_WIDTH - 2;
  localparam int BEATS = 1 << CW;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_WIDTH) - 32'd1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [31:0]     addr_q;
  logic [31:0]     way_q;
  logic [CW-1:0]   cnt;
  logic            perr_q;
  logic            beat;
  logic            last_beat;
  logic            crit_hit;

  assign beat      = (state == RECV) && mem_rd_valid;
  assign last_beat = (cnt == CW'(BEATS - 1));
  assign crit_hit  = (cnt == addr_q[OFFSET_WIDTH-1:2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The burst ends on the beat count alone; mem_rd_last only feeds the error flag.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_req) state_nxt = REQ;
      REQ:     if (mem_rd_ack) state_nxt = RECV;
      RECV:    if (beat && last_beat) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      way_q  <= '0;
      cnt    <= '0;
      perr_q <= 1'b0;
    end else begin
      if (state == IDLE && miss_req) begin
        addr_q <= miss_addr;
        way_q  <= (victim_id < 32'(LINE_NUM)) ? victim_id : '0;
        cnt    <= '0;
      end
      if (beat) begin
        cnt <= cnt + CW'(1);
        if (mem_rd_last != last_beat) perr_q <= 1'b1;
      end
    end
  end

  // Outputs are gated by state so that an asynchronous reset zeroes them at once.
  always_comb begin
    busy          = (state != IDLE);
    protocol_err  = perr_q;
    refill_done   = 1'b0;
    mem_rd_req    = 1'b0;
    mem_rd_addr   = '0;
    mem_rd_len    = '0;
    mem_rd_ready  = 1'b0;
    line_we       = 1'b0;
    line_way      = '0;
    line_word_idx = '0;
    line_wdata    = '0;
    tag_we        = 1'b0;
    tag_out       = '0;
    crit_valid    = 1'b0;
    crit_data     = '0;
    case (state)
      REQ: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = addr_q & LINE_MASK;
        mem_rd_len  = 8'(BEATS - 1);
      end
      RECV: begin
        mem_rd_ready = 1'b1;
        if (mem_rd_valid) begin
          line_we       = 1'b1;
          line_way      = way_q;
          line_word_idx = cnt;
          line_wdata    = mem_rd_data;
          if (crit_hit) begin
            crit_valid = 1'b1;
            crit_data  = mem_rd_data;
          end
        end
      end
      COMMIT: begin
        tag_we      = 1'b1;
        tag_out     = addr_q[31 -: TAG_WIDTH];
        refill_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
